// File: rtl/debounce_entradas3_pkg.sv
// Shared constants and helpers for the three-channel input debouncer.
// Debounce length, channel count and counter sizing live here.
package debounce_entradas3_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int NUM_CANAIS          = 3;

   typedef logic [NUM_CANAIS-1:0] canais_t;

   // The counter must hold up to n-1; at least one bit even for tiny n.
   function automatic int cnt_largura(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// One debounce channel: 2-FF synchroniser, persistence counter, stable level
// and a registered rising-edge pulse. 'muda' flags the edge on which the level flips.
module debounce_canal
   import debounce_entradas3_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic nivel,
   output logic pulso,
   output logic muda
);

   localparam int CNT_W = cnt_largura(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             fim;

   // The new level has persisted long enough; it is adopted on this edge.
   assign fim  = (sync2 != nivel) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign muda = fim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         nivel <= 1'b0;
         pulso <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulso <= fim & sync2;
         if (sync2 == nivel) begin
            cnt <= '0;
         end else if (fim) begin
            nivel <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_entradas3.sv
// Three independent debounced inputs feeding the 3-to-2 BCD encoder, with
// per-channel rise pulses and a shared any-change strobe.
module debounce_entradas3
   import debounce_entradas3_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_e1,
   input  logic raw_e2,
   input  logic raw_e3,
   output logic e1,
   output logic e2,
   output logic e3,
   output logic p1,
   output logic p2,
   output logic p3,
   output logic mudou
);

   canais_t raw_vec;
   canais_t nivel_vec;
   canais_t pulso_vec;
   canais_t muda_vec;

   assign raw_vec = {raw_e3, raw_e2, raw_e1};

   for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
      debounce_canal #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_canal (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_vec[i]),
         .nivel (nivel_vec[i]),
         .pulso (pulso_vec[i]),
         .muda  (muda_vec[i])
      );
   end

   assign e1 = nivel_vec[0];
   assign e2 = nivel_vec[1];
   assign e3 = nivel_vec[2];
   assign p1 = pulso_vec[0];
   assign p2 = pulso_vec[1];
   assign p3 = pulso_vec[2];

   // Registered alongside the levels so the strobe lines up with the change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mudou <= 1'b0;
      end else begin
         mudou <= |muda_vec;
      end
   end

endmodule
